input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 22 ++
 rtl/input_conditioner_channel.sv | 130 +++++++++++++
 rtl/input_conditioner.sv | 85 ++++++++
 tb/tb_input_conditioner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and helpers for the input conditioner: per-button FSM states
// and the common counter width used by debounce and autorepeat timers.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  function automatic int unsigned cnt_width(input int unsigned debounce,
                                            input int unsigned rpt_delay,
                                            input int unsigned rpt_period);
    int unsigned m;
    m = debounce;
    if (rpt_delay > m) m = rpt_delay;
    if (rpt_period > m) m = rpt_period;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One push-button channel: synchronizer, debounce FSM and autorepeat timer.
// All outputs are registered single-cycle pulses or levels.
module input_conditioner_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned BTN_ACTIVE_LOW  = 1,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
) (
  input  logic Clk,
  input  logic RstN,
  input  logic btn_pin_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic strobe_o
);

  localparam logic             RELEASED_LVL = (BTN_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PERIOD_C = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pressed;
  btn_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       rpt_q, rpt_d, rpt_cur;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   strobe_q, strobe_d;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], btn_pin_i};
  assign pressed = sync_q[SYNC_STAGES-1] ^ RELEASED_LVL;
  // A cleared timer (after press or RepeatEn low) counts down the full delay.
  assign rpt_cur = (rpt_q == '0) ? RPT_DELAY_C : rpt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    strobe_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d  = ST_HELD;
          press_d  = 1'b1;
          strobe_d = 1'b1;
          level_d  = 1'b1;
          rpt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!repeat_en_i) begin
          rpt_d = '0;
        end else if (pressed) begin
          if (rpt_cur == CNT_ONE) begin
            strobe_d = 1'b1;
            rpt_d    = RPT_PERIOD_C;
          end else begin
            rpt_d = rpt_cur - CNT_ONE;
          end
        end
        if (!pressed) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (pressed) begin
          state_d = ST_HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      sync_q    <= {SYNC_STAGES{RELEASED_LVL}};
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rpt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      strobe_q  <= strobe_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign strobe_o  = strobe_q;

endmodule

// File: rtl/input_conditioner.sv
// Button and switch input conditioner: per-button debounce/autorepeat channels
// plus synchronized switches with change pulses masked just after reset.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned BTN_COUNT       = 4,
  parameter int unsigned SW_COUNT        = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic                 Clk,
  input  logic                 RstN,
  input  logic [BTN_COUNT-1:0] Btn,
  input  logic [SW_COUNT-1:0]  Switch,
  input  logic [BTN_COUNT-1:0] RepeatEn,
  output logic [BTN_COUNT-1:0] BtnLevel,
  output logic [BTN_COUNT-1:0] BtnPress,
  output logic [BTN_COUNT-1:0] BtnRelease,
  output logic [BTN_COUNT-1:0] BtnStrobe,
  output logic [SW_COUNT-1:0]  SwitchSync,
  output logic [SW_COUNT-1:0]  SwitchChange
);

  localparam int unsigned      CNT_W     = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned      MASK_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [MASK_W-1:0] MASK_LAST = MASK_W'(SYNC_STAGES + 1);
  localparam logic [MASK_W-1:0] MASK_ONE  = MASK_W'(1);

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
    input_conditioner_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
      .CNT_W          (CNT_W)
    ) u_channel (
      .Clk        (Clk),
      .RstN       (RstN),
      .btn_pin_i  (Btn[i]),
      .repeat_en_i(RepeatEn[i]),
      .level_o    (BtnLevel[i]),
      .press_o    (BtnPress[i]),
      .release_o  (BtnRelease[i]),
      .strobe_o   (BtnStrobe[i])
    );
  end

  logic [SYNC_STAGES-1:0][SW_COUNT-1:0] sw_sync_q, sw_sync_d;
  logic [SW_COUNT-1:0]                  sw_prev_q, sw_prev_d;
  logic [SW_COUNT-1:0]                  sw_chg_q, sw_chg_d;
  logic [MASK_W-1:0]                    mask_q, mask_d;
  logic                                 mask_done;

  // Post-reset mask covers the edges where the synchronizer still fills.
  assign mask_done = (mask_q == MASK_LAST);

  always_comb begin
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], Switch};
    sw_prev_d = sw_sync_q[SYNC_STAGES-1];
    mask_d    = mask_done ? mask_q : mask_q + MASK_ONE;
    sw_chg_d  = mask_done ? (sw_sync_q[SYNC_STAGES-1] ^ sw_prev_q) : '0;
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      sw_sync_q <= '0;
      sw_prev_q <= '0;
      sw_chg_q  <= '0;
      mask_q    <= '0;
    end else begin
      sw_sync_q <= sw_sync_d;
      sw_prev_q <= sw_prev_d;
      sw_chg_q  <= sw_chg_d;
      mask_q    <= mask_d;
    end
  end

  assign SwitchSync   = sw_sync_q[SYNC_STAGES-1];
  assign SwitchChange = sw_chg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: behavioural model (stable-run
// debounce, elapsed-cycle autorepeat, delay-line synchronizers) plus literal checks.
module tb_input_conditioner;

  localparam int BC = 4;
  localparam int SC = 8;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          Clk = 1'b0;
  logic          RstN;
  logic [BC-1:0] Btn, RepeatEn, BtnLevel, BtnPress, BtnRelease, BtnStrobe;
  logic [SC-1:0] Switch, SwitchSync, SwitchChange;

  input_conditioner #(
    .BTN_COUNT(BC), .SW_COUNT(SC), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .BTN_ACTIVE_LOW(1)
  ) dut (
    .Clk(Clk), .RstN(RstN), .Btn(Btn), .Switch(Switch), .RepeatEn(RepeatEn),
    .BtnLevel(BtnLevel), .BtnPress(BtnPress), .BtnRelease(BtnRelease),
    .BtnStrobe(BtnStrobe), .SwitchSync(SwitchSync), .SwitchChange(SwitchChange)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int last_press [BC];
  int last_release [BC];
  int strobe2 [$];
  bit log2_en = 1'b0;

  // Model: sampled-pin delay lines, accepted level, disagreeing-run length,
  // and autorepeat elapsed count since last reference point.
  logic [BC-1:0] m_bpipe [S];
  logic [SC-1:0] m_spipe [S];
  logic [BC-1:0] m_level, x_press, x_rel, x_strobe;
  logic [SC-1:0] m_sprev, x_schg;
  int            m_run [BC];
  int            m_rep [BC];
  bit            m_first [BC];
  int            m_since;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < S; k++) begin
      m_bpipe[k] = '1;
      m_spipe[k] = '0;
    end
    m_level = '0; x_press = '0; x_rel = '0; x_strobe = '0;
    m_sprev = '0; x_schg = '0; m_since = 0;
    for (int i = 0; i < BC; i++) begin
      m_run[i] = 0; m_rep[i] = 0; m_first[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic s;
    bit   steady;
    x_press = '0; x_rel = '0; x_strobe = '0;
    for (int i = 0; i < BC; i++) begin
      s = ~m_bpipe[S-1][i];
      steady = m_level[i] && (m_run[i] == 0);
      if (steady) begin
        if (!RepeatEn[i]) begin
          m_rep[i] = 0; m_first[i] = 1'b0;
        end else if (s) begin
          m_rep[i]++;
          if (m_rep[i] == (m_first[i] ? RP : RD)) begin
            x_strobe[i] = 1'b1; m_rep[i] = 0; m_first[i] = 1'b1;
          end
        end
      end
      if (s != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_level[i] = s;
          m_run[i] = 0;
          if (s) begin
            x_press[i] = 1'b1; x_strobe[i] = 1'b1; m_rep[i] = 0; m_first[i] = 1'b0;
          end else begin
            x_rel[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    x_schg  = (m_since >= S + 1) ? (m_spipe[S-1] ^ m_sprev) : '0;
    m_sprev = m_spipe[S-1];
    for (int k = S - 1; k > 0; k--) begin
      m_bpipe[k] = m_bpipe[k-1];
      m_spipe[k] = m_spipe[k-1];
    end
    m_bpipe[0] = Btn;
    m_spipe[0] = Switch;
    m_since++;
  endtask

  always @(posedge Clk) begin
    int idx;
    idx = edge_n;
    edge_n++;
    if (!RstN) model_reset();
    else model_step();
    #1;
    check("level",      BtnLevel,     m_level);
    check("press",      BtnPress,     x_press);
    check("release",    BtnRelease,   x_rel);
    check("strobe",     BtnStrobe,    x_strobe);
    check("sw_sync",    SwitchSync,   m_spipe[S-1]);
    check("sw_change",  SwitchChange, x_schg);
    for (int i = 0; i < BC; i++) begin
      if (BtnPress[i])   last_press[i]   = idx;
      if (BtnRelease[i]) last_release[i] = idx;
    end
    if (log2_en && BtnStrobe[2]) strobe2.push_back(idx);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_level"},   BtnLevel,     '0);
    check({name, "_press"},   BtnPress,     '0);
    check({name, "_release"}, BtnRelease,   '0);
    check({name, "_strobe"},  BtnStrobe,    '0);
    check({name, "_sw_sync"}, SwitchSync,   '0);
    check({name, "_sw_chg"},  SwitchChange, '0);
  endtask

  initial begin
    int e0, e1, e2, e3, e4, got, j;
    int exp_off [8];
    exp_off = '{0, 10, 13, 16, 19, 22, 25, 28};
    for (int i = 0; i < BC; i++) begin
      last_press[i] = -1; last_release[i] = -1;
    end
    model_reset();
    RstN = 1'b0; Btn = '1; Switch = '0; RepeatEn = 4'b0100;
    #1;
    check_all_zero("reset");
    cyc(3);
    RstN = 1'b1;
    cyc(6);

    // Clean press on channel 0: accepted on edge S+D
    Btn[0] = 1'b0; e0 = edge_n;
    cyc(6);
    check("ch0_level_before", {31'd0, BtnLevel[0]}, 32'd0);
    cyc(2);
    check("ch0_press_latency", last_press[0] - e0, 6);
    check("ch0_level_held", {31'd0, BtnLevel[0]}, 32'd1);

    // Two-cycle bounce while held: ignored
    Btn[0] = 1'b1; cyc(2); Btn[0] = 1'b0; cyc(8);
    check("ch0_bounce_no_release", last_release[0], -1);
    check("ch0_bounce_level", {31'd0, BtnLevel[0]}, 32'd1);
    Btn[0] = 1'b1; e1 = edge_n; cyc(8);
    check("ch0_release_latency", last_release[0] - e1, 6);
    check("ch0_level_released", {31'd0, BtnLevel[0]}, 32'd0);

    // Glitch shorter than debounce on channel 1
    Btn[1] = 1'b0; cyc(3); Btn[1] = 1'b1; cyc(10);
    check("ch1_glitch_no_press", last_press[1], -1);
    check("ch1_glitch_level", {31'd0, BtnLevel[1]}, 32'd0);

    // Autorepeat on channel 2
    log2_en = 1'b1; e2 = edge_n;
    Btn[2] = 1'b0; cyc(6 + 30);
    Btn[2] = 1'b1; cyc(10);
    log2_en = 1'b0;
    check("ch2_press_latency", (strobe2.size() > 0) ? strobe2[0] - e2 : -1, 6);
    for (int k = 0; k < 8; k++) begin
      got = (k < strobe2.size()) ? strobe2[k] - strobe2[0] : -1;
      check($sformatf("ch2_repeat_off%0d", k), got, exp_off[k]);
    end

    // Switch change, then simultaneous pulse on several bits
    Switch = 8'hA5; e3 = edge_n;
    cyc(1); check("sw_sync_edge0", SwitchSync, 8'h00);
    cyc(1); check("sw_sync_edge1", SwitchSync, 8'hA5);
            check("sw_chg_edge1", SwitchChange, 8'h00);
    cyc(1); check("sw_chg_edge2", SwitchChange, 8'hA5);
    cyc(1); check("sw_chg_edge3", SwitchChange, 8'h00);

    // Reset while channel 3 held
    Btn[3] = 1'b0; cyc(10);
    check("ch3_held", {31'd0, BtnLevel[3]}, 32'd1);
    last_release[3] = -1;
    RstN = 1'b0;
    #1;
    check_all_zero("midhold_reset");
    cyc(2);
    RstN = 1'b1; e4 = edge_n; last_press[3] = -1;
    cyc(6);
    check("ch3_relevel_pending", {31'd0, BtnLevel[3]}, 32'd0);
    cyc(1);
    check("ch3_repress_latency", last_press[3] - e4, 6);
    check("ch3_no_release", last_release[3], -1);
    Btn[3] = 1'b1; cyc(10);

    // Randomized phase
    RepeatEn = '1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge Clk);
      if (!RstN) begin
        if ($urandom_range(0, 2) == 0) RstN = 1'b1;
      end else if ($urandom_range(0, 799) == 0) begin
        RstN = 1'b0;
      end
      for (int i = 0; i < BC; i++)
        if ($urandom_range(0, (4 << i) - 1) == 0) Btn[i] = ~Btn[i];
      if ($urandom_range(0, 63) == 0) begin
        j = $urandom_range(0, BC - 1);
        RepeatEn[j] = ~RepeatEn[j];
      end
      if ($urandom_range(0, 15) == 0) begin
        j = $urandom_range(0, SC - 1);
        Switch[j] = ~Switch[j];
      end
      if ($urandom_range(0, 199) == 0) Switch = SC'($urandom);
    end
    RstN = 1'b1;
    cyc(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
